// File: rtl/inst_mem_fetch.sv
// rtl/inst_mem_fetch.sv - registered-output instruction memory with program-load port and fetch handshake
module inst_mem_fetch #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 8,
  parameter logic [31:0]           BASE_ADDR  = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [31:0]           fetch_addr,
  input  logic                  flush,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [31:0]           inst_pc,
  output logic [1:0]            inst_fault
);

  localparam int unsigned DEPTH = 2**DEPTH_LOG2;
  // Byte span of the array, kept at 33 bits so a full 4 GiB span cannot wrap to zero.
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [31:0]           offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            req_fault;
  logic                  accept;

  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_data_q,  inst_data_d;
  logic [31:0]           inst_pc_q,    inst_pc_d;
  logic [1:0]            inst_fault_q, inst_fault_d;

  always_comb begin
    offset       = fetch_addr - BASE_ADDR;
    idx          = offset[DEPTH_LOG2+1:2];
    req_fault[0] = |fetch_addr[1:0];
    req_fault[1] = (fetch_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);

    fetch_ready  = !load_en && !flush && (!inst_valid_q || inst_ready);
    accept       = fetch_valid && fetch_ready;

    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;

    if (flush) begin
      inst_valid_d = 1'b0;
    end else if (accept) begin
      inst_valid_d = 1'b1;
      inst_pc_d    = fetch_addr;
      inst_fault_d = req_fault;
      inst_data_d  = (|req_fault) ? FILL_WORD : mem_q[idx];
    end else if (inst_valid_q && inst_ready) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_valid_q <= 1'b0;
      inst_data_q  <= FILL_WORD;
      inst_pc_q    <= '0;
      inst_fault_q <= '0;
    end else begin
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
    end
  end

  // Program contents survive reset; only the load port changes them.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;

endmodule
